// File: rtl/dbg_step_ctrl_if.sv
// Core debug port bundle: gating/step controls and register address out, register data back.
// The controller side uses master; the CPU core (or its model) uses slave.
interface dbg_step_ctrl_if;
    logic        debug_en;
    logic        debug_step;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data;

    modport master (
        output debug_en,
        output debug_step,
        output debug_addr,
        input  debug_data
    );

    modport slave (
        input  debug_en,
        input  debug_step,
        input  debug_addr,
        output debug_data
    );
endinterface

// File: rtl/dbg_step_ctrl.sv
// Debug step sequencer: single-step, N-step run, free-run and PC breakpoint; optional step counter (DBG_STEP_CNT_EN).
// All outputs registered; each step takes 2+SETTLE_CYC+READ_LAT cycles; buttons are pulses and never stall.
module dbg_step_ctrl #(
    parameter logic [6:0]  PC_ADDR    = 7'h00,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_step,
    input  logic                  btn_run,
    input  logic [15:0]           run_count,
    input  logic                  bp_en,
    input  logic [31:0]           bp_addr,
    input  logic [6:0]            user_addr,
    dbg_step_ctrl_if.master       dbg,
    output logic [31:0]           disp_data,
    output logic [31:0]           pc_last,
    output logic                  halted,
    output logic                  bp_hit
);

    typedef enum logic [2:0] {
        S_HALT,
        S_STEP,
        S_SETTLE,
        S_SAMPLE,
        S_FREE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(READ_LAT);
    localparam logic [1:0] VLD_LAST    = 2'(READ_LAT);

    state_t      state_q,      state_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [15:0] remaining_q,  remaining_d;
    logic        abort_q,      abort_d;
    logic        debug_en_q,   debug_en_d;
    logic        debug_step_q, debug_step_d;
    logic [6:0]  debug_addr_q, debug_addr_d;
    logic [1:0]  vld_cnt_q,    vld_cnt_d;
    logic [31:0] disp_data_q,  disp_data_d;
    logic [31:0] pc_last_q,    pc_last_d;
    logic        halted_q,     halted_d;
    logic        bp_hit_q,     bp_hit_d;
`ifdef DBG_STEP_CNT_EN
    logic [31:0] step_cnt_q,   step_cnt_d;
`endif

    logic btn_any;
    assign btn_any = btn_step | btn_run;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        abort_d     = abort_q;
        pc_last_d   = pc_last_q;
        bp_hit_d    = bp_hit_q;

        case (state_q)
            S_HALT: begin
                if (btn_run) begin
                    bp_hit_d = 1'b0;
                    if (run_count != 16'd0) begin
                        state_d     = S_STEP;
                        remaining_d = run_count;
                    end else begin
                        state_d = S_FREE;
                    end
                end else if (btn_step) begin
                    bp_hit_d    = 1'b0;
                    state_d     = S_STEP;
                    remaining_d = 16'd1;
                end
            end
            S_STEP: begin
                remaining_d = remaining_q - 16'd1;
                state_d     = S_SETTLE;
                cnt_d       = 4'd0;
                if (btn_any) abort_d = 1'b1;
            end
            S_SETTLE: begin
                if (btn_any) abort_d = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (btn_any) abort_d = 1'b1;
                if (cnt_q == SAMPLE_LAST) begin
                    pc_last_d = dbg.debug_data;
                    cnt_d     = 4'd0;
                    // A button in the final probe cycle counts as an abort too.
                    if (bp_en && (dbg.debug_data == bp_addr)) begin
                        state_d  = S_HALT;
                        bp_hit_d = 1'b1;
                    end else if ((remaining_q == 16'd0) || abort_q || btn_any) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_STEP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FREE: begin
                if (btn_any) state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase

        if (state_d == S_HALT) abort_d = 1'b0;

        debug_step_d = (state_d == S_STEP);
        debug_en_d   = (state_d != S_FREE);
        halted_d     = (state_d == S_HALT);
        debug_addr_d = (state_d == S_SAMPLE) ? PC_ADDR : user_addr;
    end

    // Read-valid tracking: data for the presented address is trusted once held READ_LAT+1 cycles.
    always_comb begin
        if (debug_addr_d != debug_addr_q) begin
            vld_cnt_d = 2'd0;
        end else if (vld_cnt_q == VLD_LAST) begin
            vld_cnt_d = vld_cnt_q;
        end else begin
            vld_cnt_d = vld_cnt_q + 2'd1;
        end

        disp_data_d = disp_data_q;
        if (state_q != S_SAMPLE) begin
`ifdef DBG_STEP_CNT_EN
            if (user_addr == 7'h7F) begin
                disp_data_d = step_cnt_q;
            end else if ((debug_addr_q == user_addr) && (vld_cnt_q == VLD_LAST)) begin
                disp_data_d = dbg.debug_data;
            end
`else
            if ((debug_addr_q == user_addr) && (vld_cnt_q == VLD_LAST)) begin
                disp_data_d = dbg.debug_data;
            end
`endif
        end
    end

`ifdef DBG_STEP_CNT_EN
    assign step_cnt_d = step_cnt_q + {31'd0, debug_step_q};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HALT;
            cnt_q        <= 4'd0;
            remaining_q  <= 16'd0;
            abort_q      <= 1'b0;
            debug_en_q   <= 1'b1;
            debug_step_q <= 1'b0;
            debug_addr_q <= 7'd0;
            vld_cnt_q    <= 2'd0;
            disp_data_q  <= 32'd0;
            pc_last_q    <= 32'd0;
            halted_q     <= 1'b1;
            bp_hit_q     <= 1'b0;
`ifdef DBG_STEP_CNT_EN
            step_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            remaining_q  <= remaining_d;
            abort_q      <= abort_d;
            debug_en_q   <= debug_en_d;
            debug_step_q <= debug_step_d;
            debug_addr_q <= debug_addr_d;
            vld_cnt_q    <= vld_cnt_d;
            disp_data_q  <= disp_data_d;
            pc_last_q    <= pc_last_d;
            halted_q     <= halted_d;
            bp_hit_q     <= bp_hit_d;
`ifdef DBG_STEP_CNT_EN
            step_cnt_q   <= step_cnt_d;
`endif
        end
    end

    assign dbg.debug_en   = debug_en_q;
    assign dbg.debug_step = debug_step_q;
    assign dbg.debug_addr = debug_addr_q;
    assign disp_data      = disp_data_q;
    assign pc_last        = pc_last_q;
    assign halted         = halted_q;
    assign bp_hit         = bp_hit_q;

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Bench for dbg_step_ctrl: table of step/run vectors with a halt scoreboard, plus hand-written corner sequences.
module tb_dbg_step_ctrl;
    localparam int SETTLE = 1;
    localparam int RL     = 1;
    localparam int PER    = SETTLE + RL + 2;
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, btn_step, btn_run, bp_en, halted, bp_hit;
    logic [15:0] run_count;
    logic [31:0] bp_addr, disp_data, pc_last;
    logic [6:0]  user_addr;

    dbg_step_ctrl_if dbg();

    dbg_step_ctrl #(.PC_ADDR(7'h00), .SETTLE_CYC(SETTLE), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst), .btn_step(btn_step), .btn_run(btn_run),
        .run_count(run_count), .bp_en(bp_en), .bp_addr(bp_addr),
        .user_addr(user_addr), .dbg(dbg), .disp_data(disp_data),
        .pc_last(pc_last), .halted(halted), .bp_hit(bp_hit)
    );

    // Core model: PC advances on a step pulse or while ungated; register reads take one cycle.
    logic [31:0] core_pc, core_rd, pc_val;
    logic        pc_load;

    function automatic logic [31:0] reg_val(input logic [6:0] a, input logic [31:0] pc);
        return (a == 7'h00) ? pc : (32'hC0DE_0000 + {25'd0, a} * 32'h111);
    endfunction

    always @(posedge clk) begin
        if (pc_load) core_pc <= pc_val;
        else if (dbg.debug_step || !dbg.debug_en) core_pc <= core_pc + 32'd4;
        core_rd <= reg_val(dbg.debug_addr, core_pc);
    end
    assign dbg.debug_data = core_rd;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] pc0;
        int          mode;      // 0 step, 1 run, 2 both buttons
        logic [15:0] rc;
        logic        bpen;
        logic [31:0] bpa;
        int          abort_at;  // press btn_run in the SETTLE after this step (0 = never)
        int          exp_steps;
        logic        exp_bp;
    } vec_t;

    typedef struct {
        int          steps;
        logic [31:0] pc;
        logic        bp;
        int          hcyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] disp_q[$];

    task automatic run_vec(input vec_t v, input int idx);
        int   steps = 0;
        int   last  = 0;
        int   cyc   = 0;
        bit   arm   = 0;
        exp_t e;
        exp_t g;
        pc_val = v.pc0; pc_load = 1'b1;
        tick;
        pc_load = 1'b0;
        bp_en = v.bpen; bp_addr = v.bpa; run_count = v.rc;
        e.steps = v.exp_steps;
        e.pc    = v.pc0 + 32'(4 * v.exp_steps);
        e.bp    = v.exp_bp;
        e.hcyc  = v.exp_steps * PER;
        sb_q.push_back(e);
        btn_step = (v.mode != 1);
        btn_run  = (v.mode != 0);
        tick;
        btn_step = 1'b0; btn_run = 1'b0;
        run_count = 16'($urandom_range(0, 65535));
        while (1) begin
            if (dbg.debug_step) begin
                steps++;
                if (steps > 1) chk($sformatf("v%0d_gap%0d", idx, steps), 32'(cyc - last), 32'(PER));
                last = cyc;
                if (steps == v.abort_at) arm = 1;
            end
            if (halted) break;
            if (cyc >= BUDGET) begin
                chk($sformatf("v%0d_timeout", idx), 32'(cyc), 32'(e.hcyc));
                break;
            end
            tick;
            cyc++;
            btn_run = 1'b0;
            if (arm) begin btn_run = 1'b1; arm = 0; end
        end
        g = sb_q.pop_front();
        chk($sformatf("v%0d_steps", idx), 32'(steps), 32'(g.steps));
        chk($sformatf("v%0d_pc_last", idx), pc_last, g.pc);
        chk($sformatf("v%0d_bp_hit", idx), {31'd0, bp_hit}, {31'd0, g.bp});
        chk($sformatf("v%0d_halt_cyc", idx), 32'(cyc), 32'(g.hcyc));
        chk($sformatf("v%0d_debug_en", idx), {31'd0, dbg.debug_en}, 32'd1);
    endtask

    vec_t        vecs[10];
    logic [6:0]  addrs[5];
    int          nsteps;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             pc0         mode rc      bpen bpa       ab st bp
        vecs[0] = '{32'h0000_0000, 0, 16'd7,   0, 32'h0,    0, 1, 1'b0};
        vecs[1] = '{32'h0000_0100, 1, 16'd5,   0, 32'h0,    0, 5, 1'b0};
        vecs[2] = '{32'h0000_0000, 1, 16'd100, 1, 32'h10,   0, 4, 1'b1};
        vecs[3] = '{32'h0000_0040, 0, 16'd0,   0, 32'h0,    0, 1, 1'b0};
        vecs[4] = '{32'h0000_0010, 1, 16'd3,   1, 32'h10,   0, 3, 1'b0};
        vecs[5] = '{32'h0000_0000, 1, 16'd3,   0, 32'h8,    0, 3, 1'b0};
        vecs[6] = '{32'h0000_001C, 1, 16'd10,  1, 32'h20,   0, 1, 1'b1};
        vecs[7] = '{32'h0000_0300, 2, 16'd3,   0, 32'h0,    0, 3, 1'b0};
        vecs[8] = '{32'h0000_0400, 1, 16'd3,   0, 32'h0,    2, 2, 1'b0};
        vecs[9] = '{32'h0000_0000, 1, 16'd1,   0, 32'h0,    0, 1, 1'b0};
        addrs = '{7'h03, 7'h05, 7'h7F, 7'h12, 7'h01};

        rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0; bp_en = 1'b0;
        run_count = 16'd0; bp_addr = 32'd0; user_addr = 7'h05;
        pc_val = 32'd0; pc_load = 1'b1;
        repeat (3) tick;
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_debug_en", {31'd0, dbg.debug_en}, 32'd1);
        chk("rst_debug_step", {31'd0, dbg.debug_step}, 32'd0);
        chk("rst_debug_addr", {25'd0, dbg.debug_addr}, 32'd0);
        chk("rst_disp_data", disp_data, 32'd0);
        chk("rst_pc_last", pc_last, 32'd0);
        chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        rst = 1'b0; pc_load = 1'b0;
        repeat (2) tick;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Free-run: core ungated until a button; breakpoint ignored.
        pc_val = 32'd0; pc_load = 1'b1;
        tick;
        pc_load = 1'b0; bp_en = 1'b1; bp_addr = 32'h8; run_count = 16'd0; btn_run = 1'b1;
        tick;
        btn_run = 1'b0;
        chk("free_debug_en", {31'd0, dbg.debug_en}, 32'd0);
        chk("free_halted", {31'd0, halted}, 32'd0);
        nsteps = 0;
        repeat (10) begin
            if (dbg.debug_step) nsteps++;
            tick;
        end
        btn_step = 1'b1;
        tick;
        btn_step = 1'b0;
        chk("free_stop_en", {31'd0, dbg.debug_en}, 32'd1);
        chk("free_stop_halted", {31'd0, halted}, 32'd1);
        chk("free_core_pc", core_pc, 32'd44);
        chk("free_bp_hit", {31'd0, bp_hit}, 32'd0);
        repeat (4) begin
            if (dbg.debug_step) nsteps++;
            tick;
        end
        chk("free_no_step", 32'(nsteps), 32'd0);
        bp_en = 1'b0;

        // Address arbitration in HALT via scoreboard.
        for (int i = 0; i < 5; i++) begin
            user_addr = addrs[i];
            disp_q.push_back(reg_val(addrs[i], core_pc));
            repeat (RL + 2) tick;
            chk($sformatf("disp_addr_%0h", addrs[i]), disp_data, disp_q.pop_front());
        end

        // User address change 3 -> 5: old value held until the new read is valid.
        user_addr = 7'h03;
        repeat (4) tick;
        user_addr = 7'h05;
        tick;
        chk("t6_hold1", disp_data, reg_val(7'h03, core_pc));
        tick;
        chk("t6_hold2", disp_data, reg_val(7'h03, core_pc));
        tick;
        chk("t6_new", disp_data, reg_val(7'h05, core_pc));

        // Display frozen during SAMPLE even when the user watches the PC register.
        user_addr = 7'h00; pc_val = 32'h200; pc_load = 1'b1;
        tick;
        pc_load = 1'b0;
        repeat (3) tick;
        chk("frz_pre", disp_data, 32'h200);
        btn_step = 1'b1;
        tick;
        btn_step = 1'b0;
        repeat (3) tick;
        chk("frz_sample", disp_data, 32'h200);
        tick;
        chk("frz_halt", disp_data, 32'h200);
        chk("frz_halted", {31'd0, halted}, 32'd1);
        tick;
        chk("frz_after", disp_data, 32'h204);
        chk("frz_pc_last", pc_last, 32'h204);

        // Reset during a step pulse drops it.
        run_count = 16'd5; btn_run = 1'b1;
        tick;
        btn_run = 1'b0;
        chk("midrst_step_seen", {31'd0, dbg.debug_step}, 32'd1);
        rst = 1'b1;
        tick;
        chk("midrst_step", {31'd0, dbg.debug_step}, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd1);
        chk("midrst_pc_last", pc_last, 32'd0);
        chk("midrst_addr", {25'd0, dbg.debug_addr}, 32'd0);
        rst = 1'b0;
        nsteps = 0;
        repeat (8) begin
            tick;
            if (dbg.debug_step) nsteps++;
        end
        chk("midrst_no_step", 32'(nsteps), 32'd0);
        chk("midrst_still_halted", {31'd0, halted}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
